// File: rtl/hslp_pipe_mul.sv
// hslp_pipe_mul: 3-stage pipelined split-level approximate multiplier.
// Each W-bit operand is split into H=W/2 halves. The four half-width
// sub-products are combined according to a per-beat accuracy mode:
//   0 exact, 1 drop LL, 2 drop LL and clear TRUNC LSBs of HL/LH, 3 HH only.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     operand handshake (a, b, mode)
//   out_valid/out_ready   result handshake (prod, out_mode)
//   approx_cnt            saturating count of accepted beats with mode != 0
// Backpressure stalls every stage at once: in_ready = !out_valid || out_ready.
module hslp_pipe_mul #(
  parameter int unsigned W     = 8,
  parameter int unsigned TRUNC = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   prod,
  output logic [1:0]       out_mode,
  output logic [CNT_W-1:0] approx_cnt
);

  localparam int unsigned H = W / 2;

  typedef logic [W-1:0]   sub_t;
  typedef logic [2*W-1:0] prod_t;

  // Clears the TRUNC LSBs of a 2H-bit cross term; TRUNC == W clears it all.
  localparam sub_t TRUNC_MASK = {W{1'b1}} << TRUNC;

  logic         advance;
  logic         accept;

  logic         s1_v_q, s1_v_d;
  sub_t         s1_a_q, s1_a_d;
  sub_t         s1_b_q, s1_b_d;
  logic [1:0]   s1_mode_q, s1_mode_d;

  logic         s2_v_q, s2_v_d;
  sub_t         s2_hh_q, s2_hh_d;
  sub_t         s2_hl_q, s2_hl_d;
  sub_t         s2_lh_q, s2_lh_d;
  sub_t         s2_ll_q, s2_ll_d;
  logic [1:0]   s2_mode_q, s2_mode_d;

  logic         s3_v_q, s3_v_d;
  prod_t        s3_prod_q, s3_prod_d;
  logic [1:0]   s3_mode_q, s3_mode_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [H-1:0] ah, al, bh, bl;
  sub_t         hh, hl, lh, ll;

  always_comb begin
    advance = !s3_v_q || out_ready;
    accept  = in_valid && advance;

    ah = s1_a_q[W-1:H];
    al = s1_a_q[H-1:0];
    bh = s1_b_q[W-1:H];
    bl = s1_b_q[H-1:0];
    // (2^H-1)^2 fits in W bits, so W-bit products never overflow.
    hh = sub_t'(ah) * sub_t'(bh);
    hl = sub_t'(ah) * sub_t'(bl);
    lh = sub_t'(al) * sub_t'(bh);
    ll = sub_t'(al) * sub_t'(bl);

    s1_v_d    = s1_v_q;
    s1_a_d    = s1_a_q;
    s1_b_d    = s1_b_q;
    s1_mode_d = s1_mode_q;
    s2_v_d    = s2_v_q;
    s2_hh_d   = s2_hh_q;
    s2_hl_d   = s2_hl_q;
    s2_lh_d   = s2_lh_q;
    s2_ll_d   = s2_ll_q;
    s2_mode_d = s2_mode_q;
    s3_v_d    = s3_v_q;
    s3_prod_d = s3_prod_q;
    s3_mode_d = s3_mode_q;
    cnt_d     = cnt_q;

    if (advance) begin
      s1_v_d = in_valid;
      if (in_valid) begin
        s1_a_d    = a;
        s1_b_d    = b;
        s1_mode_d = mode;
      end

      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_hh_d   = hh;
        s2_hl_d   = hl;
        s2_lh_d   = lh;
        s2_ll_d   = ll;
        s2_mode_d = s1_mode_q;
        case (s1_mode_q)
          2'd1: s2_ll_d = '0;
          2'd2: begin
            s2_ll_d = '0;
            s2_hl_d = hl & TRUNC_MASK;
            s2_lh_d = lh & TRUNC_MASK;
          end
          2'd3: begin
            s2_hl_d = '0;
            s2_lh_d = '0;
            s2_ll_d = '0;
          end
          default: ;
        endcase
      end

      s3_v_d = s2_v_q;
      if (s2_v_q) begin
        s3_prod_d = (prod_t'(s2_hh_q) << W)
                  + ((prod_t'(s2_hl_q) + prod_t'(s2_lh_q)) << H)
                  + prod_t'(s2_ll_q);
        s3_mode_d = s2_mode_q;
      end
    end

    if (accept && (mode != 2'd0) && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_mode_q <= '0;
      s2_v_q    <= 1'b0;
      s2_hh_q   <= '0;
      s2_hl_q   <= '0;
      s2_lh_q   <= '0;
      s2_ll_q   <= '0;
      s2_mode_q <= '0;
      s3_v_q    <= 1'b0;
      s3_prod_q <= '0;
      s3_mode_q <= '0;
      cnt_q     <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_a_q    <= s1_a_d;
      s1_b_q    <= s1_b_d;
      s1_mode_q <= s1_mode_d;
      s2_v_q    <= s2_v_d;
      s2_hh_q   <= s2_hh_d;
      s2_hl_q   <= s2_hl_d;
      s2_lh_q   <= s2_lh_d;
      s2_ll_q   <= s2_ll_d;
      s2_mode_q <= s2_mode_d;
      s3_v_q    <= s3_v_d;
      s3_prod_q <= s3_prod_d;
      s3_mode_q <= s3_mode_d;
      cnt_q     <= cnt_d;
    end
  end

  assign in_ready   = advance;
  assign out_valid  = s3_v_q;
  assign prod       = s3_prod_q;
  assign out_mode   = s3_mode_q;
  assign approx_cnt = cnt_q;

endmodule

// File: doc/hslp_pipe_mul.md
Name: hslp_pipe_mul

Overview:
- Parametrised, pipelined successor to the 8x8 hybrid split-level approximate multiplier.
- Splits each W-bit operand into high and low halves and forms four half-width sub-products (HH, HL, LH, LL).
- Combines them under a per-transaction accuracy mode: exact, or one of three approximate modes.
- Runs a 3-stage valid/ready pipeline with stall-all backpressure, and keeps a saturating count of approximate transactions for accuracy/energy profiling.

Parameters:
- W, 8, operand width; even, >= 4; H = W/2 is the half width.
- TRUNC, 2, LSBs cleared in the HL/LH sub-products in mode 2; 0 <= TRUNC <= W.
- CNT_W, 16, width of the approximate-transaction counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  pipeline can accept a beat this cycle.
- a  input  W  multiplicand, unsigned.
- b  input  W  multiplier, unsigned.
- mode  input  2  accuracy mode for this beat: 0 exact, 1 drop-LL, 2 drop-LL + truncate cross terms, 3 HH-only.
- out_valid  output  1  prod/out_mode valid.
- out_ready  input  1  downstream accepts the result.
- prod  output  2W  product, unsigned.
- out_mode  output  2  mode that travelled with this result.
- approx_cnt  output  CNT_W  accepted beats with mode != 0; saturates.

Behaviour:
- Reset (rst=1 at a clk edge):
  - all stage-valid flags = 0, so out_valid = 0.
  - prod = 0, out_mode = 0, approx_cnt = 0.
  - in_ready = 1 in the cycle after reset.
  - Reset mid-operation discards every in-flight beat with no output.
- Handshake and stalling:
  - advance = !out_valid || out_ready; in_ready = advance (combinational).
  - A beat is accepted when in_valid && in_ready.
  - When advance = 0, every stage holds its data and prod/out_mode stay stable while out_valid = 1.
  - Bubbles propagate as valid = 0; payload registers of invalid stages may be left unchanged.
- Stage 1: register a, b, mode and a valid flag.
- Stage 2: compute and register the sub-products, each 2H bits, and carry mode and valid.
  - ah = a[W-1:H], al = a[H-1:0]; bh, bl likewise from b.
  - HH = ah*bh; HL = ah*bl; LH = al*bh; LL = al*bl.
  - Mode 0: all four sub-products used unmodified.
  - Mode 1: LL forced to 0.
  - Mode 2: LL forced to 0; HL and LH with their TRUNC LSBs cleared.
  - Mode 3: HL, LH and LL all forced to 0.
- Stage 3: prod = (HH << W) + ((HL + LH) << H) + LL.
  - Computed at 2W bits; no overflow is possible because every approximate result is <= the exact result.
  - out_mode = mode carried with the beat.
- Latency: a beat accepted at edge n appears with out_valid = 1 after edge n+2 (three registers) when no stall occurs. Throughput is 1 beat/cycle.
- Ordering is strictly in order; there is no reordering or dropping.
- Counter:
  - approx_cnt increments by 1 on each accepted beat with mode != 0.
  - It holds at 2^CNT_W - 1 once reached (saturates, never wraps).
  - Only acceptance counts; stalls never double-count.
- Simultaneous accept and emit in the same cycle is legal and must not lose or duplicate a beat.

Test Plan:
- W=8, TRUNC=2: a=0xB7, b=0x5C sent in modes 0,1,2,3 back-to-back -> prod = 0x41C4, 0x4170, 0x4140, 0x3700 in that order; out_mode = 0,1,2,3; approx_cnt = 3.
- Edge operands, mode 0: a=0xFF, b=0xFF -> 0xFE01; a=0x00, b=0xA5 -> 0x0000; a=0x01, b=0x01 -> 0x0001.
  - Same in mode 3: 0xFF*0xFF -> 0xE100.
- Backpressure: stream 5 beats with out_ready=0 for 4 cycles, then 1.
  - in_ready must drop once 3 beats are held.
  - No beat is lost or duplicated; outputs stay stable while stalled; order is preserved.
- Reset mid-stream: assert rst with 2 beats in flight -> out_valid = 0 the next cycle, those beats never appear, and approx_cnt = 0.
- Counter saturation: CNT_W=3, send 10 beats in mode 1 -> approx_cnt reaches 7 and holds at 7; mode-0 beats never change it.
- Random regression: W=16, TRUNC=5, random a/b/mode with random in_valid/out_ready.
  - Compare prod against the mode formulas above computed by the scoreboard.
  - Check latency is exactly 3 cycles whenever no stall occurs.
